// File: rtl/arb_grant_sequencer_if.sv
// Purpose : handshake/bus bundle between the grant sequencer, its masters and the arbiter.
// Latency : none; this is a wiring bundle only.
// Backpressure: none; grant hold and early release are carried by gnt_valid_o / gnt_done_i.
// Ports   : req_pulse_i (strobes in), arb_req_o/arb_gnt_i (arbiter loop),
//           gnt_o/gnt_valid_o/gnt_done_i (held grant), req_drop_o (lost duplicate).
interface arb_grant_sequencer_if #(
    parameter int NUM_PORTS = 4
);
    logic [NUM_PORTS-1:0] req_pulse_i;
    logic [NUM_PORTS-1:0] arb_req_o;
    logic [NUM_PORTS-1:0] arb_gnt_i;
    logic [NUM_PORTS-1:0] gnt_o;
    logic                 gnt_valid_o;
    logic                 gnt_done_i;
    logic                 req_drop_o;

    // Sequencer side.
    modport slave (
        input  req_pulse_i,
        input  arb_gnt_i,
        input  gnt_done_i,
        output arb_req_o,
        output gnt_o,
        output gnt_valid_o,
        output req_drop_o
    );

    // Environment side: masters plus the arbiter.
    modport master (
        output req_pulse_i,
        output arb_gnt_i,
        output gnt_done_i,
        input  arb_req_o,
        input  gnt_o,
        input  gnt_valid_o,
        input  req_drop_o
    );
endinterface

// File: rtl/arb_grant_sequencer.sv
// Purpose : sticky request collection and grant hold in front of a fixed-priority arbiter.
// Latency : strobe at edge N -> arb_req_o after N -> grant captured at edge N+1; grants last
//           HOLD_CYCLES cycles (or fewer on gnt_done_i), with >=1 idle cycle between grants.
// Backpressure: none on strobes; a strobe for an already pending port is dropped and flagged.
// Ports   : clk, reset (async active-low), bus (slave modport of arb_grant_sequencer_if).
module arb_grant_sequencer #(
    parameter int NUM_PORTS   = 4,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    arb_grant_sequencer_if.slave  bus
);
    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [NUM_PORTS-1:0] r_pending;
    logic [NUM_PORTS-1:0] w_pending_nxt;
    logic [NUM_PORTS-1:0] r_gnt;
    logic [NUM_PORTS-1:0] w_gnt_nxt;
    logic                 r_gnt_vld;
    logic                 w_gnt_vld_nxt;
    logic                 r_drop;
    logic                 w_drop_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [NUM_PORTS-1:0] w_cap;
    logic [NUM_PORTS-1:0] w_clr;

    // Only pending ports can be captured; a grant for a non-pending port is ignored.
    // A multi-hot grant from the arbiter passes through unchanged.
    assign w_cap = bus.arb_gnt_i & r_pending;

    // Next-state and grant outputs.
    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = r_gnt;
        w_gnt_vld_nxt = r_gnt_vld;
        w_cnt_nxt     = r_cnt;
        w_clr         = '0;
        case (r_state)
            ST_IDLE: begin
                w_gnt_nxt     = '0;
                w_gnt_vld_nxt = 1'b0;
                if (|w_cap) begin
                    w_gnt_nxt     = w_cap;
                    w_gnt_vld_nxt = 1'b1;
                    w_clr         = w_cap;
                    w_cnt_nxt     = CNT_LOAD;
                    w_state_nxt   = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // Counter holds the remaining grant cycles after this one.
                if ((r_cnt == '0) || bus.gnt_done_i) begin
                    w_gnt_nxt     = '0;
                    w_gnt_vld_nxt = 1'b0;
                    w_state_nxt   = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
            end
            default: begin
                w_gnt_nxt     = '0;
                w_gnt_vld_nxt = 1'b0;
                w_state_nxt   = ST_IDLE;
            end
        endcase
    end

    // A strobe coinciding with the clear of its own port re-pends it (set wins),
    // so only strobes that hit a pending bit that stays pending are lost.
    always_comb begin
        w_pending_nxt = (r_pending & ~w_clr) | bus.req_pulse_i;
        w_drop_nxt    = |(bus.req_pulse_i & r_pending & ~w_clr);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_pending <= '0;
            r_gnt     <= '0;
            r_gnt_vld <= 1'b0;
            r_drop    <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
            r_gnt     <= w_gnt_nxt;
            r_gnt_vld <= w_gnt_vld_nxt;
            r_drop    <= w_drop_nxt;
            r_cnt     <= w_cnt_nxt;
        end
    end

    assign bus.arb_req_o   = r_pending;
    assign bus.gnt_o       = r_gnt;
    assign bus.gnt_valid_o = r_gnt_vld;
    assign bus.req_drop_o  = r_drop;
endmodule

// File: tb/tb_arb_grant_sequencer.sv
// Purpose : checks the grant sequencer with a fixed-priority arbiter (port 0 highest) in the loop.
// Latency : expected grants are queued at stimulus time and compared as the DUT issues them.
// Backpressure: gnt_done_i is driven for early release; every wait is bounded.
module tb_arb_grant_sequencer;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    arb_grant_sequencer_if #(.NUM_PORTS(4)) if4 ();
    arb_grant_sequencer_if #(.NUM_PORTS(4)) if1 ();

    arb_grant_sequencer #(.NUM_PORTS(4), .HOLD_CYCLES(4)) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (if4.slave)
    );

    arb_grant_sequencer #(.NUM_PORTS(4), .HOLD_CYCLES(1)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1.slave)
    );

    // Fixed-priority arbiter: lowest-index requester wins.
    function automatic logic [3:0] fp_arb(input logic [3:0] v);
        logic [3:0] r;
        r = '0;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) begin
                r    = '0;
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    assign if4.arb_gnt_i = fp_arb(if4.arb_req_o);
    assign if1.arb_gnt_i = fp_arb(if1.arb_req_o);

    typedef struct {
        logic [3:0] vec;   // expected one-hot grant
        int         len;   // expected grant length in cycles
        int         gap;   // expected idle cycles observed before it (-1: don't care)
        logic [3:0] req;   // expected arb_req_o in the first grant cycle
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic logic g_vld(input bit s);
        return s ? if1.gnt_valid_o : if4.gnt_valid_o;
    endfunction
    function automatic logic [3:0] g_gnt(input bit s);
        return s ? if1.gnt_o : if4.gnt_o;
    endfunction
    function automatic logic [3:0] g_req(input bit s);
        return s ? if1.arb_req_o : if4.arb_req_o;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] vec, input int len, input int gap, input logic [3:0] req);
        exp_t e;
        e.vec = vec;
        e.len = len;
        e.gap = gap;
        e.req = req;
        sbq.push_back(e);
    endtask

    // Pops expected grants and measures each one the DUT issues.
    task automatic run_sb(input bit sel);
        exp_t       e;
        bit         in_grant;
        int         idle;
        int         w;
        int         len;
        logic [3:0] cur;
        in_grant = 1'b0;
        idle     = 0;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            w = 0;
            while (!in_grant && w < 40) begin
                step();
                w++;
                if (g_vld(sel)) in_grant = 1'b1;
                else            idle++;
            end
            n_cmp++;
            if (!in_grant) begin
                n_err++;
                $display("FAIL grant_timeout: no grant seen, required gnt_o=%b", e.vec);
                sbq.delete();
                return;
            end
            cur = g_gnt(sel);
            n_cmp++;
            if (cur !== e.vec) begin
                n_err++;
                $display("FAIL grant_vec: gnt_o=%b required %b", cur, e.vec);
            end
            n_cmp++;
            if (g_req(sel) !== e.req) begin
                n_err++;
                $display("FAIL arb_req_in_grant: arb_req_o=%b required %b (grant %b)", g_req(sel), e.req, e.vec);
            end
            if (e.gap >= 0) begin
                n_cmp++;
                if (idle != e.gap) begin
                    n_err++;
                    $display("FAIL grant_gap: %0d idle cycles before grant %b, required %0d", idle, e.vec, e.gap);
                end
            end
            len = 1;
            while (len < 300) begin
                step();
                if (g_vld(sel) && g_gnt(sel) === cur) len++;
                else break;
            end
            n_cmp++;
            if (len != e.len) begin
                n_err++;
                $display("FAIL grant_len: grant %b lasted %0d cycles, required %0d", cur, len, e.len);
            end
            in_grant = g_vld(sel);
            idle     = in_grant ? 0 : 1;
        end
    endtask

    task automatic test_reset();
        int bad;
        reset            = 1'b0;
        if4.req_pulse_i  = '0;
        if4.gnt_done_i   = 1'b0;
        if1.req_pulse_i  = '0;
        if1.gnt_done_i   = 1'b0;
        #12;
        n_cmp++;
        if ({if4.gnt_o, if4.gnt_valid_o, if4.arb_req_o, if4.req_drop_o} !== 10'b0) begin
            n_err++;
            $display("FAIL reset_state4: gnt=%b vld=%b req=%b drop=%b required all 0",
                     if4.gnt_o, if4.gnt_valid_o, if4.arb_req_o, if4.req_drop_o);
        end
        n_cmp++;
        if ({if1.gnt_o, if1.gnt_valid_o, if1.arb_req_o, if1.req_drop_o} !== 10'b0) begin
            n_err++;
            $display("FAIL reset_state1: gnt=%b vld=%b req=%b drop=%b required all 0",
                     if1.gnt_o, if1.gnt_valid_o, if1.arb_req_o, if1.req_drop_o);
        end
        step();
        reset = 1'b1;
        step();
        // Mid-grant reset.
        if4.req_pulse_i = 4'b0100;
        step();
        if4.req_pulse_i = '0;
        step();                       // grant cycle 1
        n_cmp++;
        if (if4.gnt_valid_o !== 1'b1 || if4.gnt_o !== 4'b0100) begin
            n_err++;
            $display("FAIL reset_pre_grant: vld=%b gnt=%b required 1 0100", if4.gnt_valid_o, if4.gnt_o);
        end
        if4.req_pulse_i = 4'b1000;    // leaves a pending bit that reset must clear
        step();                       // grant cycle 2
        if4.req_pulse_i = '0;
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if (if4.gnt_o !== 4'b0 || if4.gnt_valid_o !== 1'b0 || if4.arb_req_o !== 4'b0) begin
            n_err++;
            $display("FAIL reset_async: gnt=%b vld=%b req=%b required 0000 0 0000",
                     if4.gnt_o, if4.gnt_valid_o, if4.arb_req_o);
        end
        step();
        reset = 1'b1;
        bad = 0;
        repeat (8) begin
            step();
            if (if4.gnt_valid_o !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL reset_no_regrant: gnt_valid_o high in %0d cycles after reset, required 0", bad);
        end
    endtask

    task automatic test_single();
        if4.req_pulse_i = 4'b0100;
        step();
        if4.req_pulse_i = '0;
        n_cmp++;
        if (if4.arb_req_o !== 4'b0100 || if4.gnt_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL single_pending: arb_req=%b vld=%b required 0100 0", if4.arb_req_o, if4.gnt_valid_o);
        end
        push(4'b0100, 4, 0, 4'b0000);
        run_sb(1'b0);
        repeat (3) step();
    endtask

    task automatic test_simultaneous();
        if4.req_pulse_i = 4'b1011;
        step();
        if4.req_pulse_i = '0;
        n_cmp++;
        if (if4.arb_req_o !== 4'b1011) begin
            n_err++;
            $display("FAIL simul_pending: arb_req=%b required 1011", if4.arb_req_o);
        end
        push(4'b0001, 4, 0, 4'b1010);
        push(4'b0010, 4, 1, 4'b1000);
        push(4'b1000, 4, 1, 4'b0000);
        run_sb(1'b0);
        repeat (3) step();
    endtask

    task automatic test_early_release();
        int w;
        if4.req_pulse_i = 4'b0011;
        push(4'b0001, 2, 1, 4'b0010);
        push(4'b0010, 4, 1, 4'b0000);
        fork
            run_sb(1'b0);
            begin
                step();
                if4.req_pulse_i = '0;
                w = 0;
                while (!if4.gnt_valid_o && w < 20) begin
                    step();
                    w++;
                end
                step();                  // grant cycle 2
                if4.gnt_done_i = 1'b1;
                step();                  // idle gap: done must be ignored here
                step();                  // next grant captured regardless
                if4.gnt_done_i = 1'b0;
            end
        join
        repeat (3) step();
    endtask

    task automatic test_duplicates();
        int drops;
        int w;
        drops = 0;
        if4.req_pulse_i = 4'b0001;
        push(4'b0001, 4, 1, 4'b0000);
        push(4'b0010, 4, 1, 4'b0000);
        push(4'b0010, 4, 1, 4'b0000);
        fork
            run_sb(1'b0);
            begin
                step();
                if4.req_pulse_i = '0;
                step();                  // grant 0001 cycle 1
                if4.req_pulse_i = 4'b0010;
                step();
                drops += int'(if4.req_drop_o);
                step();                  // second strobe while pending
                drops += int'(if4.req_drop_o);
                if4.req_pulse_i = '0;
                w = 0;
                while (!(if4.gnt_valid_o && if4.gnt_o == 4'b0010) && w < 40) begin
                    step();
                    drops += int'(if4.req_drop_o);
                    w++;
                end
                if4.req_pulse_i = 4'b0010;   // strobe during its own grant
                step();
                drops += int'(if4.req_drop_o);
                if4.req_pulse_i = '0;
                repeat (14) begin
                    step();
                    drops += int'(if4.req_drop_o);
                end
            end
        join
        n_cmp++;
        if (drops != 1) begin
            n_err++;
            $display("FAIL dup_drop_count: req_drop_o high %0d cycles, required 1", drops);
        end
        repeat (3) step();
    endtask

    task automatic test_hold_one();
        if1.req_pulse_i = 4'b1111;
        step();
        if1.req_pulse_i = '0;
        push(4'b0001, 1, 0, 4'b1110);
        push(4'b0010, 1, 1, 4'b1100);
        push(4'b0100, 1, 1, 4'b1000);
        push(4'b1000, 1, 1, 4'b0000);
        run_sb(1'b1);
        repeat (3) step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_early_release();
        test_duplicates();
        test_hold_one();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
